// File: rtl/hilo_pkg.sv
// Shared op codes, FSM state type and dmu launch codes for the HI/LO controller.
package hilo_pkg;

    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_MULTU = 4'd6;
    localparam logic [3:0] OP_DIVU  = 4'd7;
    localparam logic [3:0] OP_DIV   = 4'd11;
    localparam logic [3:0] OP_MTHI  = 4'd12;
    localparam logic [3:0] OP_MTLO  = 4'd13;
    localparam logic [3:0] OP_MFHI  = 4'd14;
    localparam logic [3:0] OP_MFLO  = 4'd15;

    localparam logic [1:0] BEGIN_NONE = 2'd0;
    localparam logic [1:0] BEGIN_DIV  = 2'd1;
    localparam logic [1:0] BEGIN_MUL  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_ctrl_if.sv
// EX-side op bus and dmu-side operand/result bus of the HI/LO controller.
interface hilo_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             op_valid;
    logic [3:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             flush;
    logic             stall;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] md_a;
    logic [WIDTH-1:0] md_b;
    logic [3:0]       md_m;
    logic [1:0]       md_begin;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    modport master (
        output op_valid, op, rs_val, rt_val, flush, md_hi, md_lo,
        input  stall, rd_data, hi, lo, md_a, md_b, md_m, md_begin
    );

    modport slave (
        input  op_valid, op, rs_val, rt_val, flush, md_hi, md_lo,
        output stall, rd_data, hi, lo, md_a, md_b, md_m, md_begin
    );
endinterface

// File: rtl/hilo_ctrl.sv
// Issue/commit control for the multiply/divide unit: launches dmu ops, counts their
// latency, commits results into HI/LO and services MTHI/MTLO/MFHI/MFLO.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 7,
    parameter int unsigned DIV_LAT = 36
) (
    input  logic        clk,
    input  logic        rst,
    hilo_ctrl_if.slave  bus
);

    localparam int unsigned CW = $clog2(DIV_LAT + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] md_a_q, md_a_d;
    logic [WIDTH-1:0] md_b_q, md_b_d;
    logic [3:0]       md_m_q, md_m_d;
    logic [1:0]       md_begin_q, md_begin_d;

    logic idle;
    logic accept;
    logic last;

    assign idle   = (state_q == ST_IDLE);
    // A flush in the same cycle as an accept suppresses the accept entirely.
    assign accept = bus.op_valid & idle & ~bus.flush;
    assign last   = (cnt_q == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            md_a_q     <= '0;
            md_b_q     <= '0;
            md_m_q     <= '0;
            md_begin_q <= BEGIN_NONE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            md_a_q     <= md_a_d;
            md_b_q     <= md_b_d;
            md_m_q     <= md_m_d;
            md_begin_q <= md_begin_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        md_a_d     = md_a_q;
        md_b_d     = md_b_q;
        md_m_d     = md_m_q;
        md_begin_d = BEGIN_NONE;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul(bus.op) || is_div(bus.op)) begin
                        md_a_d     = bus.rs_val;
                        md_b_d     = bus.rt_val;
                        md_m_d     = bus.op;
                        state_d    = ST_BUSY;
                        md_begin_d = is_mul(bus.op) ? BEGIN_MUL : BEGIN_DIV;
                        cnt_d      = is_mul(bus.op) ? CW'(MUL_LAT) : CW'(DIV_LAT);
                    end else if (bus.op == OP_MTHI) begin
                        hi_d = bus.rs_val;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d = bus.rs_val;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                // A flush landing on the commit edge still cancels the write.
                if (bus.flush) begin
                    state_d = last ? ST_IDLE : ST_DRAIN;
                end else if (last) begin
                    hi_d    = bus.md_hi;
                    lo_d    = bus.md_lo;
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - CW'(1);
                if (last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bus.rd_data = '0;
        if (bus.op_valid && idle) begin
            if (bus.op == OP_MFHI) begin
                bus.rd_data = hi_q;
            end else if (bus.op == OP_MFLO) begin
                bus.rd_data = lo_q;
            end
        end
    end

    assign bus.stall    = bus.op_valid & ~idle;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.md_a     = md_a_q;
    assign bus.md_b     = md_b_q;
    assign bus.md_m     = md_m_q;
    assign bus.md_begin = md_begin_q;

endmodule
